// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-word pipeline: field positions of the
// decoded control word and the packed layouts held in each stage register.
package ctrl_pkg;

  localparam int CTRL_W = 11;
  localparam int REG_W  = 5;

  localparam int BIT_REG_DST   = 0;
  localparam int BIT_ALU_SRC   = 1;
  localparam int BIT_MEM_TO_REG = 2;
  localparam int BIT_REG_WRITE = 3;
  localparam int BIT_MEM_READ  = 4;
  localparam int BIT_MEM_WRITE = 5;
  localparam int BIT_BRANCH    = 6;
  localparam int BIT_JUMP      = 7;
  localparam int BIT_EXT_OP    = 8;
  localparam int BIT_ALU_OP_LO = 9;
  localparam int BIT_ALU_OP_HI = 10;

  localparam logic [CTRL_W-1:0] BUBBLE = '0;

  // Member order is MSB first, so this overlays the raw word bit for bit.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       ext_op;
    logic       jump;
    logic       branch;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             ctrl;
    logic [REG_W-1:0]  rt;
  } id_ex_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ex_mem_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } mem_wb_t;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register for control bits. A bubble loads all zeros,
// which can never write a register or memory.
module ctrl_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_d;
  logic [W-1:0] stage_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    stage_d = d_i;
    if (bubble_i) stage_d = '0;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state uses non-blocking assignment so all stages update from pre-edge values.
    if (rst_i) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign q_o = stage_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoded control fields to EX/MEM/WB, detects load-use hazards,
// inserts one bubble per hazard, gates IF/ID flushes and counts stall cycles.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] Ctrl_i,
  input  logic              IdValid_i,
  input  logic [REG_W-1:0]  Rs_i,
  input  logic [REG_W-1:0]  Rt_i,
  input  logic              Flush_i,
  output logic              Stall_o,
  output logic              Flush_o,
  output logic              RegDst_ex_o,
  output logic              ALUSrc_ex_o,
  output logic              ExtOp_ex_o,
  output logic [1:0]        ALUOp_ex_o,
  output logic [REG_W-1:0]  RtEx_o,
  output logic              MemRead_mem_o,
  output logic              MemWrite_mem_o,
  output logic              RegWrite_wb_o,
  output logic              MemtoReg_wb_o,
  output logic [CNT_W-1:0]  StallCnt_o
);

  id_ex_t  id_ex_d,  id_ex_q;
  ex_mem_t ex_mem_d, ex_mem_q;
  mem_wb_t mem_wb_d, mem_wb_q;

  logic             stall;
  logic             rt_hit;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  always_comb begin
    rt_hit = (id_ex_q.rt != '0) && ((id_ex_q.rt == Rs_i) || (id_ex_q.rt == Rt_i));
    stall  = id_ex_q.ctrl.mem_read & IdValid_i & rt_hit;
  end

  always_comb begin
    id_ex_d      = '{ctrl: ctrl_t'(Ctrl_i), rt: Rt_i};
    ex_mem_d     = '{mem_to_reg: id_ex_q.ctrl.mem_to_reg,
                     reg_write:  id_ex_q.ctrl.reg_write,
                     mem_read:   id_ex_q.ctrl.mem_read,
                     mem_write:  id_ex_q.ctrl.mem_write};
    mem_wb_d     = '{mem_to_reg: ex_mem_q.mem_to_reg,
                     reg_write:  ex_mem_q.reg_write};
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  ctrl_stage_reg #(.W($bits(id_ex_t))) u_id_ex (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubble_i (stall | ~IdValid_i),
    .d_i      (id_ex_d),
    .q_o      (id_ex_q)
  );

  // Downstream stages never freeze; the stall only holds PC and IF/ID.
  ctrl_stage_reg #(.W($bits(ex_mem_t))) u_ex_mem (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubble_i (1'b0),
    .d_i      (ex_mem_d),
    .q_o      (ex_mem_q)
  );

  ctrl_stage_reg #(.W($bits(mem_wb_t))) u_mem_wb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubble_i (1'b0),
    .d_i      (mem_wb_d),
    .q_o      (mem_wb_q)
  );

  // Branch and Jump ride in ID/EX for completeness but nothing downstream reads them.
  logic unused_branch_jump;
  assign unused_branch_jump = id_ex_q.ctrl.branch ^ id_ex_q.ctrl.jump;

  assign Stall_o        = stall;
  assign Flush_o        = Flush_i & IdValid_i & ~stall;
  assign RegDst_ex_o    = id_ex_q.ctrl.reg_dst;
  assign ALUSrc_ex_o    = id_ex_q.ctrl.alu_src;
  assign ExtOp_ex_o     = id_ex_q.ctrl.ext_op;
  assign ALUOp_ex_o     = id_ex_q.ctrl.alu_op;
  assign RtEx_o         = id_ex_q.rt;
  assign MemRead_mem_o  = ex_mem_q.mem_read;
  assign MemWrite_mem_o = ex_mem_q.mem_write;
  assign RegWrite_wb_o  = mem_wb_q.reg_write;
  assign MemtoReg_wb_o  = mem_wb_q.mem_to_reg;
  assign StallCnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomised bench for ctrl_pipe: a history queue of accepted words models
// the pipeline; a 16-bit and a 4-bit counter instance share the stimulus.
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [10:0] ctrl_i;
  logic        id_valid_i;
  logic [4:0]  rs_i, rt_i;
  logic        flush_i;

  logic        stall_o, flush_o, reg_dst_ex, alu_src_ex, ext_op_ex;
  logic [1:0]  alu_op_ex;
  logic [4:0]  rt_ex;
  logic        mem_read_mem, mem_write_mem, reg_write_wb, mem_to_reg_wb;
  logic [15:0] stall_cnt;

  logic        s4_stall, s4_flush, s4_reg_dst, s4_alu_src, s4_ext_op;
  logic [1:0]  s4_alu_op;
  logic [4:0]  s4_rt_ex;
  logic        s4_mem_read, s4_mem_write, s4_reg_write, s4_mem_to_reg;
  logic [3:0]  s4_cnt;

  always #5 clk = ~clk;

  ctrl_pipe #(.CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .Ctrl_i(ctrl_i), .IdValid_i(id_valid_i),
    .Rs_i(rs_i), .Rt_i(rt_i), .Flush_i(flush_i),
    .Stall_o(stall_o), .Flush_o(flush_o),
    .RegDst_ex_o(reg_dst_ex), .ALUSrc_ex_o(alu_src_ex), .ExtOp_ex_o(ext_op_ex),
    .ALUOp_ex_o(alu_op_ex), .RtEx_o(rt_ex),
    .MemRead_mem_o(mem_read_mem), .MemWrite_mem_o(mem_write_mem),
    .RegWrite_wb_o(reg_write_wb), .MemtoReg_wb_o(mem_to_reg_wb),
    .StallCnt_o(stall_cnt)
  );

  ctrl_pipe #(.CNT_W(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_i), .Ctrl_i(ctrl_i), .IdValid_i(id_valid_i),
    .Rs_i(rs_i), .Rt_i(rt_i), .Flush_i(flush_i),
    .Stall_o(s4_stall), .Flush_o(s4_flush),
    .RegDst_ex_o(s4_reg_dst), .ALUSrc_ex_o(s4_alu_src), .ExtOp_ex_o(s4_ext_op),
    .ALUOp_ex_o(s4_alu_op), .RtEx_o(s4_rt_ex),
    .MemRead_mem_o(s4_mem_read), .MemWrite_mem_o(s4_mem_write),
    .RegWrite_wb_o(s4_reg_write), .MemtoReg_wb_o(s4_mem_to_reg),
    .StallCnt_o(s4_cnt)
  );

  typedef struct {
    logic [10:0] ctrl;
    logic [4:0]  rt;
  } word_t;

  // pipe_hist[0] is the word in EX, [1] in MEM, [2] in WB.
  word_t pipe_hist[$];
  int    stall_total;
  int    n_checks;
  int    n_errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    word_t z;
    z.ctrl = '0;
    z.rt   = '0;
    pipe_hist = {z, z, z};
    stall_total = 0;
  endtask

  // One clock: drive inputs after the falling edge, check, then let the rising edge act.
  task automatic cycle(input logic r, input logic [10:0] c, input logic v,
                       input logic [4:0] s, input logic [4:0] t, input logic f,
                       input bit do_check = 1'b1);
    word_t ex, mem, wb, acc;
    bit    exp_stall;
    rst_i = r; ctrl_i = c; id_valid_i = v; rs_i = s; rt_i = t; flush_i = f;
    #1;
    ex  = pipe_hist[0];
    mem = pipe_hist[1];
    wb  = pipe_hist[2];
    exp_stall = ex.ctrl[4] && v && (ex.rt != 0) && (ex.rt == s || ex.rt == t);
    if (do_check) begin
      check("stall",      {31'd0, stall_o},       {31'd0, exp_stall});
      check("flush",      {31'd0, flush_o},       {31'd0, f && v && !exp_stall});
      check("regdst_ex",  {31'd0, reg_dst_ex},    {31'd0, ex.ctrl[0]});
      check("alusrc_ex",  {31'd0, alu_src_ex},    {31'd0, ex.ctrl[1]});
      check("extop_ex",   {31'd0, ext_op_ex},     {31'd0, ex.ctrl[8]});
      check("aluop_ex",   {30'd0, alu_op_ex},     {30'd0, ex.ctrl[10:9]});
      check("rt_ex",      {27'd0, rt_ex},         {27'd0, ex.rt});
      check("memrd_mem",  {31'd0, mem_read_mem},  {31'd0, mem.ctrl[4]});
      check("memwr_mem",  {31'd0, mem_write_mem}, {31'd0, mem.ctrl[5]});
      check("regwr_wb",   {31'd0, reg_write_wb},  {31'd0, wb.ctrl[3]});
      check("memtoreg_wb",{31'd0, mem_to_reg_wb}, {31'd0, wb.ctrl[2]});
      check("stall_cnt",  {16'd0, stall_cnt},     (stall_total > 65535) ? 32'd65535 : stall_total);
      check("stall_cnt4", {28'd0, s4_cnt},        (stall_total > 15) ? 32'd15 : stall_total);
      check("stall4",     {31'd0, s4_stall},      {31'd0, exp_stall});
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (exp_stall || !v) begin
        acc.ctrl = '0;
        acc.rt   = '0;
      end else begin
        acc.ctrl = c;
        acc.rt   = t;
      end
      pipe_hist.push_front(acc);
      void'(pipe_hist.pop_back());
      if (exp_stall) stall_total++;
    end
    @(negedge clk);
  endtask

  localparam logic [10:0] RTYPE = 11'h609;
  localparam logic [10:0] LW    = 11'h31E;

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst_i = 1'b1; ctrl_i = '0; id_valid_i = 1'b0; rs_i = '0; rt_i = '0; flush_i = 1'b0;
    @(negedge clk);

    // Reset held two cycles with a live R-type on the inputs.
    cycle(1'b1, RTYPE, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0);
    cycle(1'b1, RTYPE, 1'b1, 5'd1, 5'd2, 1'b0);
    check("rst_cnt",   {16'd0, stall_cnt}, 32'd0);
    check("rst_regwr", {31'd0, reg_write_wb}, 32'd0);

    // R-type travels EX -> MEM -> WB.
    cycle(1'b0, RTYPE, 1'b1, 5'd1, 5'd2, 1'b0);
    check("rtype_regdst", {31'd0, reg_dst_ex}, 32'd1);
    check("rtype_aluop",  {30'd0, alu_op_ex},  32'd3);
    cycle(1'b0, '0, 1'b0, 5'd0, 5'd0, 1'b0);
    cycle(1'b0, '0, 1'b0, 5'd0, 5'd0, 1'b0);
    check("rtype_wb_regwr",    {31'd0, reg_write_wb},  32'd1);
    check("rtype_wb_memtoreg", {31'd0, mem_to_reg_wb}, 32'd0);

    // lw r5 then add using r5: one stall, bubble in EX, add two edges after lw.
    cycle(1'b0, LW,    1'b1, 5'd1, 5'd5, 1'b0);
    cycle(1'b0, RTYPE, 1'b1, 5'd5, 5'd6, 1'b0);
    check("lu_bubble_regdst", {31'd0, reg_dst_ex}, 32'd0);
    check("lu_cnt",           {16'd0, stall_cnt},  32'd1);
    cycle(1'b0, RTYPE, 1'b1, 5'd5, 5'd6, 1'b0);
    check("lu_add_in_ex", {31'd0, reg_dst_ex}, 32'd1);

    // Load into r0 never stalls.
    cycle(1'b0, LW,    1'b1, 5'd2, 5'd0, 1'b0);
    cycle(1'b0, RTYPE, 1'b1, 5'd0, 5'd0, 1'b0);

    // Flush suppressed during the stall, honoured on re-decode; lw, use, use.
    cycle(1'b0, LW,    1'b1, 5'd1, 5'd7, 1'b0);
    cycle(1'b0, RTYPE, 1'b1, 5'd7, 5'd3, 1'b1);
    cycle(1'b0, RTYPE, 1'b1, 5'd7, 5'd3, 1'b1);
    cycle(1'b0, RTYPE, 1'b1, 5'd3, 5'd7, 1'b0);
    cycle(1'b0, RTYPE, 1'b1, 5'd0, 5'd0, 1'b1);
    cycle(1'b0, RTYPE, 1'b0, 5'd0, 5'd0, 1'b1);

    // Twenty load-use pairs drive the 4-bit counter into saturation.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, LW,    1'b1, 5'd1, 5'd3, 1'b0);
      cycle(1'b0, RTYPE, 1'b1, 5'd3, 5'd4, 1'b0);
      cycle(1'b0, RTYPE, 1'b1, 5'd3, 5'd4, 1'b0);
    end
    check("sat_cnt4", {28'd0, s4_cnt}, 32'd15);

    // Random traffic with small register numbers so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      logic [10:0] c;
      c = 11'($urandom);
      c[4] = ($urandom_range(0, 99) < 40);
      cycle(($urandom_range(0, 99) < 2), c, ($urandom_range(0, 99) < 85),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 25));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Control-word pipeline and load-use hazard unit for the five-stage MIPS core. It takes the decoded control word from the ID-stage decoder and carries each field to the stage that consumes it (EX, MEM, WB). It detects load-use hazards and inserts bubbles, and gates IF/ID flushes requested by branch and jump resolution. It sits between the ID-stage decoder and the EX/MEM/WB datapath registers.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk_i  in  1  core clock, all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- Ctrl_i  in  11  decoded control word from ID decoder (field layout in ctrl_pkg)
- IdValid_i  in  1  ID instruction is valid; 0 injects a bubble
- Rs_i  in  5  rs field of ID instruction
- Rt_i  in  5  rt field of ID instruction
- Flush_i  in  1  branch taken or jump resolved in ID this cycle
- Stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- Flush_o  out  1  clear IF/ID this cycle (combinational)
- RegDst_ex_o, ALUSrc_ex_o, ExtOp_ex_o  out  1 each  EX-stage controls
- ALUOp_ex_o  out  2  EX-stage ALU op class
- RtEx_o  out  5  rt of instruction in EX
- MemRead_mem_o, MemWrite_mem_o  out  1 each  MEM-stage controls
- RegWrite_wb_o, MemtoReg_wb_o  out  1 each  WB-stage controls
- StallCnt_o  out  CNT_W  number of stall cycles since reset, saturating

## Operation
- Control word bits: [0]RegDst [1]ALUSrc [2]MemtoReg [3]RegWrite [4]MemRead [5]MemWrite [6]Branch [7]Jump [8]ExtOp [10:9]ALUOp.
- Bubble: all-zero word. It cannot write registers or memory.
- Three stage registers: ID/EX (full word plus Rt), EX/MEM (MemtoReg, RegWrite, MemRead, MemWrite), MEM/WB (MemtoReg, RegWrite).
- Load-use hazard: Stall_o = ID/EX.MemRead & IdValid_i & (RtEx != 0) & (RtEx == Rs_i | RtEx == Rt_i).
- ID/EX loads a bubble when Stall_o=1 or IdValid_i=0. Otherwise it loads Ctrl_i and Rt_i.
- EX/MEM and MEM/WB always advance. Stall does not freeze the downstream stages.
- Flush_o = Flush_i & ~Stall_o. While stalled, the ID instruction is re-decoded next cycle, so the flush re-asserts then. Flush_i does not bubble ID/EX; the branch or jump itself proceeds.
- Flush_i with IdValid_i=0 is ignored (Flush_o=0).
- StallCnt increments on each cycle with Stall_o=1 and saturates at all-ones.
- No Ctrl_i field is interpreted beyond MemRead for hazard detection. Branch and Jump bits are carried to ID/EX only.

## Timing
- Reset: every stage register, RtEx_o and StallCnt_o are 0 on the cycle after a rst_i edge. Stall_o and Flush_o are 0 while the pipeline holds zeros.
- Latency: a word accepted at edge N appears on the EX outputs after N, on MEM after N+1, and on WB after N+2.
- Stall_o and Flush_o are combinational, valid in the same cycle as their inputs.
- A stall lasts exactly one cycle per load-use pair, because the bubble clears ID/EX.MemRead.
- rst_i mid-stall: reset wins, registers clear, StallCnt returns to 0.
- Back-to-back lw then use then use: only the first use stalls.

## Structure
- ctrl_pkg: CTRL_W=11, bit-index constants for each field, BUBBLE=11'b0.
- Sub-module ctrl_stage_reg (parameter W). Synchronous reset plus a bubble input; instantiated three times.
- Hazard compare and counter live in ctrl_pipe.

## Test plan
- rst_i high 2 cycles with Ctrl_i=0x609, IdValid_i=1 -> all outputs 0, StallCnt_o=0.
- R-type 0x609 at edge N -> RegDst_ex_o=1, ALUOp_ex_o=2'b11 after N; RegWrite_wb_o=1, MemtoReg_wb_o=0 after N+2.
- lw 0x31E with Rt=5, then add with Rs=5 -> Stall_o=1 for one cycle, EX outputs a bubble, add's word reaches EX two edges after lw, StallCnt_o=1.
- lw with Rt=0, then use with Rs=0 -> Stall_o stays 0.
- Flush_i=1 during a stall cycle -> Flush_o=0; next cycle with Flush_i=1 -> Flush_o=1.
- CNT_W=4 instance, 20 load-use stalls -> StallCnt_o holds at 15.
